pdu_run_ctrl: RTL

Parametrised successor to the PDU run-control logic. It gates the CPU through a clock-enable and supports STOP, multi-instruction STEP and RUN modes. It provides a table of NUM_BRK individually enabled PC breakpoints and skips the breakpoint the CPU is already parked on when resuming. It also records a stop cause and counts enabled cycles. It sits between the debounced button pulses in the PDU and the CPU's clock/enable path.

---
 rtl/pdu_run_ctrl_if.sv | 50 +++++
 rtl/pdu_run_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/pdu_run_ctrl_if.sv
// Bus between the PDU front panel / CPU path and pdu_run_ctrl.
// Optional cyc_limit input exists only when PDU_CYCLE_LIMIT_EN is defined.
interface pdu_run_ctrl_if #(
    parameter int ADDR_W  = 32,
    parameter int NUM_BRK = 4,
    parameter int STEP_W  = 8,
    parameter int CNT_W   = 32,
    parameter int IDX_W   = (NUM_BRK > 1 ? $clog2(NUM_BRK) : 1)
);
    // step_p/cont_p/halt_p/brk_we/cnt_clr are single-cycle strobes sampled on
    // posedge clk; there is no ready/backpressure, each strobe acts the cycle it is seen.
    logic              step_p;
    logic              cont_p;
    logic              halt_p;
    logic [STEP_W-1:0] step_n;
    logic              brk_we;
    logic [IDX_W-1:0]  brk_idx;
    logic [ADDR_W-1:0] brk_addr;
    logic              brk_vld_wr;
    logic [ADDR_W-1:0] chk_pc;
    logic              cnt_clr;
`ifdef PDU_CYCLE_LIMIT_EN
    logic [CNT_W-1:0]  cyc_limit;
`endif
    logic              cpu_en;
    logic              run;
    logic [2:0]        stop_cause;
    logic [IDX_W-1:0]  hit_idx;
    logic [NUM_BRK-1:0] brk_vld;
    logic [CNT_W-1:0]  cyc_cnt;
    logic [1:0]        state_dbg;

    modport master (
`ifdef PDU_CYCLE_LIMIT_EN
        output cyc_limit,
`endif
        output step_p, cont_p, halt_p, step_n, brk_we, brk_idx, brk_addr,
        output brk_vld_wr, chk_pc, cnt_clr,
        input  cpu_en, run, stop_cause, hit_idx, brk_vld, cyc_cnt, state_dbg
    );

    modport slave (
`ifdef PDU_CYCLE_LIMIT_EN
        input  cyc_limit,
`endif
        input  step_p, cont_p, halt_p, step_n, brk_we, brk_idx, brk_addr,
        input  brk_vld_wr, chk_pc, cnt_clr,
        output cpu_en, run, stop_cause, hit_idx, brk_vld, cyc_cnt, state_dbg
    );
endinterface

// File: rtl/pdu_run_ctrl.sv
// PDU run control: STOP/STEP/RUN clock-enable gating, PC breakpoints, stop cause, cycle counter.
// Define PDU_CYCLE_LIMIT_EN to add the cyc_limit stop (cause 4).
module pdu_run_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int NUM_BRK = 4,
    parameter int STEP_W  = 8,
    parameter int CNT_W   = 32,
    parameter int IDX_W   = (NUM_BRK > 1 ? $clog2(NUM_BRK) : 1)
) (
    input  logic            clk,
    input  logic            rstn,
    pdu_run_ctrl_if.slave   bus
);
    localparam logic [1:0] ST_STOP = 2'd0;
    localparam logic [1:0] ST_STEP = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    localparam logic [2:0] CAUSE_STEP  = 3'd1;
    localparam logic [2:0] CAUSE_BRK   = 3'd2;
    localparam logic [2:0] CAUSE_HALT  = 3'd3;
    localparam logic [2:0] CAUSE_LIMIT = 3'd4;

    logic [1:0]         state_q, state_d;
    logic [STEP_W-1:0]  step_cnt_q, step_cnt_d;
    logic               skip_q, skip_d;
    logic [2:0]         cause_q, cause_d;
    logic [IDX_W-1:0]   hit_q, hit_d;
    logic [ADDR_W-1:0]  brk_addr_q [NUM_BRK];
    logic [ADDR_W-1:0]  brk_addr_d [NUM_BRK];
    logic [NUM_BRK-1:0] brk_vld_q, brk_vld_d;
    logic [CNT_W-1:0]   cyc_q, cyc_d;

    logic [NUM_BRK-1:0] match;
    logic [IDX_W-1:0]   hit_sel;
    logic               eff_match;
    logic               limit_hit;
    logic               cpu_en;
    logic [CNT_W-1:0]   cyc_inc;

    assign cpu_en  = (state_q != ST_STOP);
    assign cyc_inc = cyc_q + CNT_W'(1);

    // Lowest matching slot wins, so scan from the top down.
    always_comb begin
        hit_sel = '0;
        for (int i = 0; i < NUM_BRK; i++) begin
            match[i] = brk_vld_q[i] && (brk_addr_q[i] == bus.chk_pc);
        end
        for (int i = NUM_BRK - 1; i >= 0; i--) begin
            if (match[i]) hit_sel = IDX_W'(i);
        end
        eff_match = (|match) && !skip_q;
    end

`ifdef PDU_CYCLE_LIMIT_EN
    assign limit_hit = (bus.cyc_limit != '0) && (cyc_inc == bus.cyc_limit);
`else
    assign limit_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        step_cnt_d = step_cnt_q;
        skip_d     = skip_q;
        cause_d    = cause_q;
        hit_d      = hit_q;
        case (state_q)
            ST_STOP: begin
                if (bus.step_p) begin
                    step_cnt_d = (bus.step_n == '0) ? STEP_W'(1) : bus.step_n;
                    skip_d     = 1'b1;
                    state_d    = ST_STEP;
                end else if (bus.cont_p) begin
                    skip_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_STEP, ST_RUN: begin
                // Skip only shields the first enabled cycle after a resume.
                skip_d = 1'b0;
                if (bus.halt_p) begin
                    state_d = ST_STOP;
                    cause_d = CAUSE_HALT;
                end else if (limit_hit) begin
                    state_d = ST_STOP;
                    cause_d = CAUSE_LIMIT;
                end else if (eff_match) begin
                    state_d = ST_STOP;
                    cause_d = CAUSE_BRK;
                    hit_d   = hit_sel;
                end else if (state_q == ST_STEP) begin
                    if (step_cnt_q == STEP_W'(1)) begin
                        state_d = ST_STOP;
                        cause_d = CAUSE_STEP;
                    end else begin
                        step_cnt_d = step_cnt_q - STEP_W'(1);
                    end
                end
            end
            default: state_d = ST_STOP;
        endcase
    end

    // Out-of-range indices simply match no slot and are dropped.
    always_comb begin
        brk_vld_d = brk_vld_q;
        for (int i = 0; i < NUM_BRK; i++) begin
            brk_addr_d[i] = brk_addr_q[i];
            if (bus.brk_we && (bus.brk_idx == IDX_W'(i))) begin
                brk_addr_d[i] = bus.brk_addr;
                brk_vld_d[i]  = bus.brk_vld_wr;
            end
        end
    end

    always_comb begin
        cyc_d = cyc_q;
        if (bus.cnt_clr)  cyc_d = '0;
        else if (cpu_en)  cyc_d = cyc_inc;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_STOP;
            step_cnt_q <= '0;
            skip_q     <= 1'b0;
            cause_q    <= '0;
            hit_q      <= '0;
            brk_vld_q  <= '0;
            cyc_q      <= '0;
            for (int i = 0; i < NUM_BRK; i++) brk_addr_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            step_cnt_q <= step_cnt_d;
            skip_q     <= skip_d;
            cause_q    <= cause_d;
            hit_q      <= hit_d;
            brk_vld_q  <= brk_vld_d;
            cyc_q      <= cyc_d;
            for (int i = 0; i < NUM_BRK; i++) brk_addr_q[i] <= brk_addr_d[i];
        end
    end

    assign bus.cpu_en     = cpu_en;
    assign bus.run        = (state_q == ST_RUN);
    assign bus.stop_cause = cause_q;
    assign bus.hit_idx    = hit_q;
    assign bus.brk_vld    = brk_vld_q;
    assign bus.cyc_cnt    = cyc_q;
    assign bus.state_dbg  = state_q;
endmodule
